// File: rtl/boron_pkg.sv
// Shared BORON definitions: round count, key width, S-box tables, FSM states.
package boron_pkg;

  localparam int BORON_ROUNDS = 25;
  localparam int BORON_KEY_W  = 80;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    KEYFWD = 3'd1,
    READY  = 3'd2,
    DEC    = 3'd3,
    HOLD   = 3'd4
  } boron_state_e;

  function automatic logic [3:0] boron_sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'hE;  4'h1: return 4'h4;  4'h2: return 4'hB;  4'h3: return 4'h1;
      4'h4: return 4'h7;  4'h5: return 4'h9;  4'h6: return 4'hC;  4'h7: return 4'hA;
      4'h8: return 4'hD;  4'h9: return 4'h2;  4'hA: return 4'h0;  4'hB: return 4'hF;
      4'hC: return 4'h8;  4'hD: return 4'h5;  4'hE: return 4'h3;  default: return 4'h6;
    endcase
  endfunction

  function automatic logic [3:0] boron_inv_sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'hA;  4'h1: return 4'h3;  4'h2: return 4'h9;  4'h3: return 4'hE;
      4'h4: return 4'h1;  4'h5: return 4'hD;  4'h6: return 4'hF;  4'h7: return 4'h4;
      4'h8: return 4'hC;  4'h9: return 4'h5;  4'hA: return 4'h7;  4'hB: return 4'h2;
      4'hC: return 4'h6;  4'hD: return 4'h8;  4'hE: return 4'h0;  default: return 4'hB;
    endcase
  endfunction

endpackage

// File: rtl/boron_inv_key_step.sv
// Combinational inverse key-schedule step: K(r+1) -> K(r) using round counter r.
module boron_inv_key_step #(
  parameter int KEY_W = 80
) (
  input  logic [KEY_W-1:0] i_key,
  input  logic [4:0]       i_rnd,
  output logic [KEY_W-1:0] o_key
);

  logic [3:0]       w_nib;
  logic [KEY_W-1:0] w_t;

  s_box #(.INV(1'b1)) u_isb (
    .i_x (i_key[3:0]),
    .o_y (w_nib)
  );

  // undo counter XOR and low-nibble S-box, then rotate right by 13
  assign w_t   = {i_key[KEY_W-1:64], i_key[63:59] ^ i_rnd, i_key[58:4], w_nib};
  assign o_key = {w_t[12:0], w_t[KEY_W-1:13]};

endmodule

// File: rtl/round_dec.sv
// One BORON decryption round: inverse permutation, inverse S-box layer, add round key.
module round_dec (
  input  logic [63:0] i_state,
  input  logic [63:0] i_rk,
  output logic [63:0] o_state
);

  logic [15:0] w_r0, w_r1, w_r2, w_r3;
  logic [15:0] w_w0, w_w1, w_w2, w_w3;
  logic [63:0] w_ip, w_sb;

  // Forward layer rotates words by 1/4/7/9 then folds w0 into w1 and w2 into w3;
  // undo the folds first, then rotate back.
  assign w_r0 = i_state[15:0];
  assign w_r1 = i_state[31:16] ^ i_state[15:0];
  assign w_r2 = i_state[47:32];
  assign w_r3 = i_state[63:48] ^ i_state[47:32];

  assign w_w0 = {w_r0[0],   w_r0[15:1]};
  assign w_w1 = {w_r1[3:0], w_r1[15:4]};
  assign w_w2 = {w_r2[6:0], w_r2[15:7]};
  assign w_w3 = {w_r3[8:0], w_r3[15:9]};
  assign w_ip = {w_w3, w_w2, w_w1, w_w0};

  s_box_layer_dec #(.NUM_LANES(16)) u_sbl (
    .i_x (w_ip),
    .o_y (w_sb)
  );

  assign o_state = w_sb ^ i_rk;

endmodule

// File: rtl/s_box.sv
// Single 4-bit BORON S-box; INV selects the inverse table.
module s_box
  import boron_pkg::*;
#(
  parameter bit INV = 1'b0
) (
  input  logic [3:0] i_x,
  output logic [3:0] o_y
);

  // table lookup, direction fixed at elaboration
  always_comb begin
    o_y = INV ? boron_inv_sbox(i_x) : boron_sbox(i_x);
  end

endmodule

// File: rtl/s_box_layer_dec.sv
// Inverse S-box layer: one inverse S-box per nibble of the 64-bit state.
module s_box_layer_dec #(
  parameter int NUM_LANES = 16
) (
  input  logic [NUM_LANES-1:0][3:0] i_x,
  output logic [NUM_LANES-1:0][3:0] o_y
);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    s_box #(.INV(1'b1)) u_sb (
      .i_x (i_x[g]),
      .o_y (o_y[g])
    );
  end

endmodule

// File: rtl/boron_dec_stream.sv
// BORON decryption core: precomputes K25 once per key, then decrypts one
// block per 25-cycle pass with a valid/ready handshake on both sides.
module boron_dec_stream
  import boron_pkg::*;
#(
  parameter int ROUNDS = BORON_ROUNDS,
  parameter int KEY_W  = BORON_KEY_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_load,
  input  logic [KEY_W-1:0] masterKey,
  output logic             key_busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      cipherText,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      plainText
);

  // round counter is XORed into a 5-bit key field, so ROUNDS must stay <= 32
  localparam logic [4:0] LAST_RND = 5'(ROUNDS - 1);

  boron_state_e     r_state;
  logic [1:0]       r_rst_sync;
  logic [KEY_W-1:0] r_key;
  logic [KEY_W-1:0] r_final;
  logic [63:0]      r_blk;
  logic [63:0]      r_out;
  logic [4:0]       r_rnd;

  logic             w_rst_n;
  logic [KEY_W-1:0] w_rot;
  logic [3:0]       w_fsb;
  logic [KEY_W-1:0] w_fwd_key;
  logic [KEY_W-1:0] w_inv_key;
  logic [63:0]      w_round_out;

  // assert asynchronously, release on a clock edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // forward key step: rotate left 13, S-box low nibble, XOR counter
  assign w_rot = {r_key[KEY_W-14:0], r_key[KEY_W-1:KEY_W-13]};

  s_box #(.INV(1'b0)) u_fsb (
    .i_x (w_rot[3:0]),
    .o_y (w_fsb)
  );

  assign w_fwd_key = {w_rot[KEY_W-1:64], w_rot[63:59] ^ r_rnd, w_rot[58:4], w_fsb};

  boron_inv_key_step #(.KEY_W(KEY_W)) u_ikey (
    .i_key (r_key),
    .i_rnd (r_rnd),
    .o_key (w_inv_key)
  );

  round_dec u_round (
    .i_state (r_blk),
    .i_rk    (w_inv_key[63:0]),
    .o_state (w_round_out)
  );

  // control FSM; key_load overrides every state, including a pending handshake
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= IDLE;
      r_key   <= '0;
      r_final <= '0;
      r_blk   <= '0;
      r_out   <= '0;
      r_rnd   <= '0;
    end else if (key_load) begin
      r_state <= KEYFWD;
      r_key   <= masterKey;
      r_rnd   <= '0;
    end else begin
      case (r_state)
        KEYFWD: begin
          r_key <= w_fwd_key;
          if (r_rnd == LAST_RND) begin
            r_final <= w_fwd_key;
            r_state <= READY;
          end else begin
            r_rnd <= r_rnd + 5'd1;
          end
        end
        READY: begin
          if (in_valid) begin
            r_blk   <= cipherText ^ r_final[63:0];
            r_key   <= r_final;
            r_rnd   <= LAST_RND;
            r_state <= DEC;
          end
        end
        DEC: begin
          r_key <= w_inv_key;
          r_blk <= w_round_out;
          if (r_rnd == 5'd0) begin
            r_out   <= w_round_out;
            r_state <= HOLD;
          end else begin
            r_rnd <= r_rnd - 5'd1;
          end
        end
        HOLD: begin
          if (out_ready) r_state <= READY;
        end
        default: r_state <= r_state;
      endcase
    end
  end

  // status outputs are pure decodes of the state register
  assign in_ready  = (r_state == READY);
  assign key_busy  = (r_state == KEYFWD);
  assign out_valid = (r_state == HOLD);
  assign plainText = r_out;

endmodule

// File: tb/tb_boron_dec_stream.sv
// Directed bench for boron_dec_stream with a reference BORON encryptor and
// an expected-plaintext scoreboard.
module tb_boron_dec_stream;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        key_load = 1'b0;
  logic [79:0] masterKey = '0;
  logic        key_busy;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] cipherText = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] plainText;

  logic [79:0] ik_in = '0;
  logic [4:0]  ik_rnd = '0;
  logic [79:0] ik_out;

  int total = 0;
  int bad   = 0;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  boron_dec_stream #(.ROUNDS(25), .KEY_W(80)) dut (
    .clk(clk), .reset(reset), .key_load(key_load), .masterKey(masterKey),
    .key_busy(key_busy), .in_valid(in_valid), .in_ready(in_ready),
    .cipherText(cipherText), .out_valid(out_valid), .out_ready(out_ready),
    .plainText(plainText)
  );

  boron_inv_key_step #(.KEY_W(80)) u_ik (
    .i_key(ik_in), .i_rnd(ik_rnd), .o_key(ik_out)
  );

  // ---------------- reference model ----------------
  function automatic logic [3:0] m_sb(input logic [3:0] x);
    logic [3:0] t[16];
    t = '{4'hE,4'h4,4'hB,4'h1,4'h7,4'h9,4'hC,4'hA,4'hD,4'h2,4'h0,4'hF,4'h8,4'h5,4'h3,4'h6};
    return t[x];
  endfunction

  function automatic logic [79:0] m_fstep(input logic [79:0] k, input int rc);
    logic [79:0] r;
    logic [4:0]  c;
    c = 5'(rc);
    r = {k[66:0], k[79:67]};
    r[3:0]   = m_sb(r[3:0]);
    r[63:59] = r[63:59] ^ c;
    return r;
  endfunction

  function automatic logic [63:0] m_perm(input logic [63:0] s);
    logic [15:0] w0, w1, w2, w3, r0, r1, r2, r3;
    w0 = s[15:0]; w1 = s[31:16]; w2 = s[47:32]; w3 = s[63:48];
    r0 = {w0[14:0], w0[15]};
    r1 = {w1[11:0], w1[15:12]};
    r2 = {w2[8:0],  w2[15:9]};
    r3 = {w3[6:0],  w3[15:7]};
    return {r3 ^ r2, r2, r1 ^ r0, r0};
  endfunction

  function automatic logic [63:0] m_enc(input logic [63:0] pt, input logic [79:0] key);
    logic [63:0] s;
    logic [79:0] k;
    s = pt;
    k = key;
    for (int r = 0; r < 25; r++) begin
      s = s ^ k[63:0];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = m_sb(s[4*n +: 4]);
      s = m_perm(s);
      k = m_fstep(k, r);
    end
    return s ^ k[63:0];
  endfunction

  function automatic logic [79:0] m_k25(input logic [79:0] key);
    logic [79:0] k;
    k = key;
    for (int r = 0; r < 25; r++) k = m_fstep(k, r);
    return k;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // pulse key_load, then count cycles with key_busy high
  task automatic load_key(input logic [79:0] k, output int n);
    key_load = 1'b1;
    masterKey = k;
    tick();
    key_load = 1'b0;
    n = 0;
    while (key_busy && n < 100) begin tick(); n++; end
  endtask

  // present a block until accepted; expected plaintext goes to the scoreboard
  task automatic send(input logic [63:0] ct, input logic [63:0] pt);
    int n;
    in_valid = 1'b1;
    cipherText = ct;
    n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    if (n >= 100) chk("accept_timeout", 80'(n), 80'd0);
    tick();
    in_valid = 1'b0;
    sb_q.push_back(pt);
  endtask

  // wait for a result, check latency and data, then complete the handshake
  task automatic get_out(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    chk({tag, "_latency"}, 80'(n), 80'd25);
    if (sb_q.size() == 0) chk({tag, "_sb_empty"}, 80'd1, 80'd0);
    else chk({tag, "_data"}, 80'(plainText), 80'(sb_q.pop_front()));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_done_ready"}, 80'(in_ready), 80'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    logic seen;
    logic [79:0] ka, kb, kc, mk, k;
    logic [63:0] p1, p2, hold_v;

    // inverse schedule walks K25 back to the master key
    for (int t = 0; t < 1000; t++) begin
      mk = {16'($urandom), $urandom, $urandom};
      k = m_k25(mk);
      for (int r = 24; r >= 0; r--) begin
        ik_in = k;
        ik_rnd = 5'(r);
        #1;
        k = ik_out;
      end
      chk("inv_sched", k, mk);
    end

    // reset state
    #3;
    chk("rst_in_ready", 80'(in_ready), 80'd0);
    chk("rst_out_valid", 80'(out_valid), 80'd0);
    chk("rst_key_busy", 80'(key_busy), 80'd0);
    chk("rst_plain", 80'(plainText), 80'd0);
    reset = 1'b1;
    in_valid = 1'b1;
    repeat (5) tick();
    chk("idle_in_ready", 80'(in_ready), 80'd0);
    chk("idle_no_out", 80'(out_valid), 80'd0);
    in_valid = 1'b0;

    // zero vector
    load_key(80'h0, n);
    chk("zero_busy_cycles", 80'(n), 80'd25);
    chk("zero_ready", 80'(in_ready), 80'd1);
    send(m_enc(64'h0, 80'h0), 64'h0);
    get_out("zero");

    // ones vector
    load_key({80{1'b1}}, n);
    chk("ones_busy_cycles", 80'(n), 80'd25);
    send(m_enc({64{1'b1}}, {80{1'b1}}), {64{1'b1}});
    get_out("ones");

    // out_ready outside HOLD does nothing
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("oready_idle_ready", 80'(in_ready), 80'd1);
    chk("oready_idle_valid", 80'(out_valid), 80'd0);

    // backpressure with a second block held by the sender
    ka = {16'($urandom), $urandom, $urandom};
    p1 = {$urandom, $urandom};
    p2 = {$urandom, $urandom};
    load_key(ka, n);
    send(m_enc(p1, ka), p1);
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    chk("bp_latency", 80'(n), 80'd25);
    hold_v = plainText;
    in_valid = 1'b1;
    cipherText = m_enc(p2, ka);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (plainText !== hold_v || !out_valid || in_ready) seen = 1'b1;
    end
    chk("bp_stable", 80'(seen), 80'd0);
    chk("bp_data", 80'(plainText), 80'(sb_q.pop_front()));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_ready_after", 80'(in_ready), 80'd1);
    chk("bp_valid_after", 80'(out_valid), 80'd0);
    tick();
    in_valid = 1'b0;
    sb_q.push_back(p2);
    chk("bp_accepted", 80'(in_ready), 80'd0);
    get_out("b2b");

    // key reload aborts a block in flight
    kb = {16'($urandom), $urandom, $urandom};
    send(m_enc(p1, ka), p1);
    void'(sb_q.pop_back());
    repeat (12) tick();
    key_load = 1'b1;
    masterKey = kb;
    tick();
    key_load = 1'b0;
    chk("abort_busy", 80'(key_busy), 80'd1);
    n = 0;
    seen = 1'b0;
    while (key_busy && n < 100) begin tick(); n++; if (out_valid) seen = 1'b1; end
    chk("abort_busy_cycles", 80'(n), 80'd25);
    chk("abort_no_out", 80'(seen), 80'd0);
    send(m_enc(p2, kb), p2);
    get_out("newkey");

    // key_load on the accept edge wins
    kc = {16'($urandom), $urandom, $urandom};
    in_valid = 1'b1;
    cipherText = m_enc(p1, kb);
    key_load = 1'b1;
    masterKey = kc;
    tick();
    in_valid = 1'b0;
    key_load = 1'b0;
    chk("coll_busy", 80'(key_busy), 80'd1);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("coll_no_out", 80'(seen), 80'd0);
    chk("coll_ready", 80'(in_ready), 80'd1);
    send(m_enc(p1, kc), p1);
    get_out("coll_key");

    // asynchronous reset in the middle of decryption
    send(m_enc(p2, kc), p2);
    void'(sb_q.pop_back());
    repeat (7) tick();
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_in_ready", 80'(in_ready), 80'd0);
    chk("mid_rst_out_valid", 80'(out_valid), 80'd0);
    chk("mid_rst_busy", 80'(key_busy), 80'd0);
    chk("mid_rst_plain", 80'(plainText), 80'd0);
    #3;
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (in_ready || out_valid) seen = 1'b1;
    end
    chk("post_rst_quiet", 80'(seen), 80'd0);
    load_key(kc, n);
    chk("post_rst_busy", 80'(n), 80'd25);
    send(m_enc(p2, kc), p2);
    get_out("post_rst");

    chk("sb_drained", 80'(sb_q.size()), 80'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
